sa_tile_sequencer: RTL and testbench

- Controller that runs one output-stationary matrix tile on the N×N systolic array.
- Fetches activation and weight vectors from local operand buffers and applies diagonal skew. Drives the array's sa_iv, sa_mac_iv and sa_bias_iv phases, loads the bias columns, waits for sa_ov, then writes the N result columns to the output buffer.
- Sits between the layer scheduler (start/done) and one systolic array instance.

---
 rtl/sa_tile_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_sa_tile_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sa_tile_sequencer.sv
// Tile controller for an N x N output-stationary systolic array: streams skewed
// A/W operands, loads bias columns, then drains the N result columns to the output buffer.
module sa_tile_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 8,
  parameter int MAX_K      = 256,
  parameter int OV_TIMEOUT = 64,
  localparam int AW        = $clog2(MAX_K),
  localparam int BW        = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    start,
  input  logic [AW:0]             k_len,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    a_rd_en,
  output logic [AW-1:0]           a_rd_addr,
  input  logic [N*DATA_WIDTH-1:0] a_rd_data,
  output logic                    w_rd_en,
  output logic [AW-1:0]           w_rd_addr,
  input  logic [N*DATA_WIDTH-1:0] w_rd_data,
  output logic                    b_rd_en,
  output logic [BW-1:0]           b_rd_addr,
  input  logic [N*DATA_WIDTH-1:0] b_rd_data,
  output logic                    sa_iv,
  output logic                    sa_mac_iv,
  output logic                    sa_bias_iv,
  output logic [N*DATA_WIDTH-1:0] row_A_o,
  output logic [N*DATA_WIDTH-1:0] col_W_o,
  output logic [N*DATA_WIDTH-1:0] bias_col_o,
  input  logic                    sa_ov,
  input  logic [N*DATA_WIDTH-1:0] psum_i,
  output logic                    out_wr_en,
  output logic [BW-1:0]           out_wr_addr,
  output logic [N*DATA_WIDTH-1:0] out_wr_data
);

  localparam int DW = DATA_WIDTH;
  // One counter serves MAC index, bias column, timeout and drain column.
  localparam int CW = $clog2(MAX_K + 2*N + OV_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_STAR, S_MAC, S_BPRE, S_BIAS, S_WAITOV, S_DRAIN, S_DONE
  } state_t;

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [AW:0]   r_k, w_k_nx;
  logic          r_err, w_err_nx;
  logic          r_rd_v;
  logic [CW-1:0] w_k_ext;
  logic          w_mac_last, w_rd;

  assign w_k_ext    = CW'(r_k);
  assign w_mac_last = (r_cnt == w_k_ext + CW'(2*N-2));
  assign w_rd       = (r_state == S_MAC) && (r_cnt < w_k_ext);

  // State, counter, latched K, sticky error and read-issued flag
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_cnt   <= {CW{1'b0}};
      r_k     <= {(AW+1){1'b0}};
      r_err   <= 1'b0;
      r_rd_v  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_k     <= w_k_nx;
      r_err   <= w_err_nx;
      r_rd_v  <= w_rd;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_k_nx     = r_k;
    w_err_nx   = r_err;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_err_nx   = 1'b0;
          w_k_nx     = k_len;
          w_cnt_nx   = {CW{1'b0}};
          w_state_nx = (k_len == {(AW+1){1'b0}}) ? S_DONE : S_STAR;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_STAR: begin
        w_state_nx = S_MAC;
        w_cnt_nx   = {CW{1'b0}};
      end
      S_MAC: begin
        if (w_mac_last) begin
          w_state_nx = S_BPRE;
          w_cnt_nx   = {CW{1'b0}};
        end else begin
          w_cnt_nx   = r_cnt + CW'(1);
        end
      end
      S_BPRE: begin
        w_state_nx = S_BIAS;
        w_cnt_nx   = {CW{1'b0}};
      end
      S_BIAS: begin
        if (r_cnt == CW'(N-1)) begin
          w_state_nx = S_WAITOV;
          w_cnt_nx   = {CW{1'b0}};
        end else begin
          w_cnt_nx   = r_cnt + CW'(1);
        end
      end
      S_WAITOV: begin
        // The cycle sa_ov first rises is column 0, so drain resumes at column 1.
        if (sa_ov) begin
          w_state_nx = S_DRAIN;
          w_cnt_nx   = CW'(1);
        end else if (r_cnt == CW'(OV_TIMEOUT-1)) begin
          w_state_nx = S_DONE;
          w_err_nx   = 1'b1;
        end else begin
          w_cnt_nx   = r_cnt + CW'(1);
        end
      end
      S_DRAIN: begin
        if (!sa_ov) begin
          w_state_nx = S_DONE;
          w_err_nx   = 1'b1;
        end else if (r_cnt == CW'(N-1)) begin
          w_state_nx = S_DONE;
        end else begin
          w_cnt_nx   = r_cnt + CW'(1);
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Control, buffer-port and result-write outputs decoded from state
  always_comb begin
    busy        = (r_state != S_IDLE) && (r_state != S_DONE);
    done        = (r_state == S_DONE);
    err         = r_err;
    sa_iv       = busy;
    sa_mac_iv   = (r_state == S_MAC) && (r_cnt != {CW{1'b0}});
    sa_bias_iv  = (r_state == S_BIAS);
    a_rd_en     = w_rd;
    w_rd_en     = w_rd;
    a_rd_addr   = w_rd ? r_cnt[AW-1:0] : {AW{1'b0}};
    w_rd_addr   = w_rd ? r_cnt[AW-1:0] : {AW{1'b0}};
    b_rd_en     = 1'b0;
    b_rd_addr   = {BW{1'b0}};
    bias_col_o  = {(N*DW){1'b0}};
    out_wr_en   = 1'b0;
    out_wr_addr = {BW{1'b0}};
    out_wr_data = {(N*DW){1'b0}};
    if (r_state == S_BPRE) begin
      b_rd_en = 1'b1;
    end else if (r_state == S_BIAS) begin
      bias_col_o = b_rd_data;
      if (r_cnt < CW'(N-1)) begin
        b_rd_en   = 1'b1;
        b_rd_addr = BW'(r_cnt + CW'(1));
      end else begin
        b_rd_en   = 1'b0;
      end
    end else begin
      b_rd_en = 1'b0;
    end
    if (sa_ov && ((r_state == S_WAITOV) || (r_state == S_DRAIN))) begin
      out_wr_en   = 1'b1;
      out_wr_addr = (r_state == S_DRAIN) ? r_cnt[BW-1:0] : {BW{1'b0}};
      out_wr_data = psum_i;
    end else begin
      out_wr_en   = 1'b0;
    end
  end

  // Diagonal skew: lane i delayed i stages; lanes with no read behind them carry zero.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [DW-1:0] w_a_in, w_w_in;
    assign w_a_in = r_rd_v ? a_rd_data[gi*DW +: DW] : {DW{1'b0}};
    assign w_w_in = r_rd_v ? w_rd_data[gi*DW +: DW] : {DW{1'b0}};
    if (gi == 0) begin : g_comb
      assign row_A_o[gi*DW +: DW] = w_a_in;
      assign col_W_o[gi*DW +: DW] = w_w_in;
    end else begin : g_dly
      logic [DW-1:0] r_a_sh [gi];
      logic [DW-1:0] r_w_sh [gi];
      // Per-lane skew shift registers
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          for (int j = 0; j < gi; j++) begin
            r_a_sh[j] <= {DW{1'b0}};
            r_w_sh[j] <= {DW{1'b0}};
          end
        end else begin
          r_a_sh[0] <= w_a_in;
          r_w_sh[0] <= w_w_in;
          for (int j = 1; j < gi; j++) begin
            r_a_sh[j] <= r_a_sh[j-1];
            r_w_sh[j] <= r_w_sh[j-1];
          end
        end
      end
      assign row_A_o[gi*DW +: DW] = r_a_sh[gi-1];
      assign col_W_o[gi*DW +: DW] = r_w_sh[gi-1];
    end
  end

endmodule

// File: tb/tb_sa_tile_sequencer.sv
// Bench for sa_tile_sequencer: models the operand buffers and the array, and predicts
// every output per cycle from the tile timeline (STAR, MAC, BPRE, BIAS, wait/drain, DONE).
module tb_sa_tile_sequencer;
  localparam int DW = 8, N = 8, MAX_K = 256, OVT = 64, AW = 8, BW = 3, VW = N*DW;

  logic clk = 1'b0;
  logic nrst, start, busy, done, err;
  logic [AW:0] k_len;
  logic a_rd_en, w_rd_en, b_rd_en, sa_iv, sa_mac_iv, sa_bias_iv, sa_ov, out_wr_en;
  logic [AW-1:0] a_rd_addr, w_rd_addr;
  logic [BW-1:0] b_rd_addr, out_wr_addr;
  logic [VW-1:0] a_rd_data, w_rd_data, b_rd_data, row_A_o, col_W_o, bias_col_o, psum_i, out_wr_data;

  sa_tile_sequencer #(.DATA_WIDTH(DW), .N(N), .MAX_K(MAX_K), .OV_TIMEOUT(OVT)) dut (
    .clk(clk), .nrst(nrst), .start(start), .k_len(k_len), .busy(busy), .done(done), .err(err),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .sa_iv(sa_iv), .sa_mac_iv(sa_mac_iv), .sa_bias_iv(sa_bias_iv),
    .row_A_o(row_A_o), .col_W_o(col_W_o), .bias_col_o(bias_col_o),
    .sa_ov(sa_ov), .psum_i(psum_i),
    .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data)
  );

  always #5 clk = ~clk;

  typedef struct { int k; int d; int cols; bit mid; int e_err; int e_nwr; } vec_t;
  vec_t tab[8];

  int n_chk = 0, n_pass = 0, cur_t = 0, last_err = 0;
  logic [VW-1:0] mem_a [MAX_K];
  logic [VW-1:0] mem_w [MAX_K];
  logic [VW-1:0] mem_b [N];
  logic [VW-1:0] pcol  [N];
  bit p_a, p_w, p_b;
  logic [AW-1:0] p_aa, p_wa;
  logic [BW-1:0] p_ba;

  function automatic logic [VW-1:0] junk();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0d actual=%h required=%h", nm, cur_t, act, exp);
  endtask

  task automatic sample_reqs();
    p_a = a_rd_en; p_aa = a_rd_addr;
    p_w = w_rd_en; p_wa = w_rd_addr;
    p_b = b_rd_en; p_ba = b_rd_addr;
  endtask

  // Buffers answer one cycle after the request; unrequested cycles carry garbage.
  task automatic respond();
    @(posedge clk); #1;
    a_rd_data = p_a ? mem_a[p_aa] : junk();
    w_rd_data = p_w ? mem_w[p_wa] : junk();
    b_rd_data = p_b ? mem_b[p_ba] : junk();
  endtask

  task automatic idle_cycles(input int n, input int e_err);
    for (int i = 0; i < n; i++) begin
      start = 1'b0; sa_ov = 1'b0; psum_i = junk();
      @(negedge clk); cur_t = -1;
      chk("idle_busy", busy, 64'd0);       chk("idle_done", done, 64'd0);
      chk("idle_sa_iv", sa_iv, 64'd0);     chk("idle_mac_iv", sa_mac_iv, 64'd0);
      chk("idle_bias_iv", sa_bias_iv, 64'd0);
      chk("idle_a_rd", a_rd_en, 64'd0);    chk("idle_w_rd", w_rd_en, 64'd0);
      chk("idle_b_rd", b_rd_en, 64'd0);    chk("idle_wr", out_wr_en, 64'd0);
      chk("idle_row", row_A_o, 64'd0);     chk("idle_col", col_W_o, 64'd0);
      chk("idle_bias", bias_col_o, 64'd0); chk("idle_err", err, VW'(e_err));
      sample_reqs();
      respond();
    end
  endtask

  // Runs one tile. d = wait cycles before sa_ov, cols = columns sa_ov stays high (-1: never).
  task automatic run_tile(input int k, input int d, input int cols, input bit mid,
                          input int abort_t, input int tab_err, input int tab_nwr);
    int L, R, tdone, e_err, e_nwr, nwr, ndone, m, c, w, src;
    bit in_mac, in_bias, e_brd, e_wr;
    logic [VW-1:0] er, ew;
    for (int j = 0; j < k; j++) begin mem_a[j] = junk(); mem_w[j] = junk(); end
    for (int j = 0; j < N; j++) begin mem_b[j] = junk(); pcol[j] = junk(); end
    L = k + 2*N - 1;
    R = L + 2 + N;
    if (cols < 0)       begin tdone = R + OVT;          e_err = 1; e_nwr = 0;    end
    else if (cols >= N) begin tdone = R + d + N;        e_err = 0; e_nwr = N;    end
    else                begin tdone = R + d + cols + 1; e_err = 1; e_nwr = cols; end
    start = 1'b1; k_len = (AW+1)'(k); sa_ov = 1'b0;
    @(negedge clk); sample_reqs(); respond();
    start = 1'b0; k_len = (AW+1)'($urandom);
    nwr = 0; ndone = 0;
    for (int t = 0; t <= tdone; t++) begin
      w = t - R;
      if (t < R) begin sa_ov = 1'($urandom); psum_i = junk(); end
      else if (cols >= 0 && w >= d && w < d + cols) begin sa_ov = 1'b1; psum_i = pcol[w-d]; end
      else begin sa_ov = 1'b0; psum_i = junk(); end
      start = (mid && t == 5);
      @(negedge clk); cur_t = t;
      m = t - 1; c = t - L - 2;
      in_mac  = (t >= 1) && (t <= L);
      in_bias = (c >= 0) && (c < N);
      e_brd   = (t == L + 1) || (in_bias && c < N - 1);
      e_wr    = (w >= d) && (w < d + e_nwr) && (t < tdone);
      for (int i = 0; i < N; i++) begin
        src = m - 1 - i;
        er[i*DW +: DW] = (src >= 0 && src < k) ? mem_a[src][i*DW +: DW] : 8'd0;
        ew[i*DW +: DW] = (src >= 0 && src < k) ? mem_w[src][i*DW +: DW] : 8'd0;
      end
      chk("busy", busy, VW'(t < tdone));      chk("done", done, VW'(t == tdone));
      chk("sa_iv", sa_iv, VW'(t < tdone));    chk("mac_iv", sa_mac_iv, VW'(in_mac && m >= 1));
      chk("a_rd_en", a_rd_en, VW'(in_mac && m < k));
      chk("w_rd_en", w_rd_en, VW'(in_mac && m < k));
      if (in_mac && m < k) begin
        chk("a_rd_addr", a_rd_addr, VW'(m)); chk("w_rd_addr", w_rd_addr, VW'(m));
      end
      chk("b_rd_en", b_rd_en, VW'(e_brd));
      if (e_brd) chk("b_rd_addr", b_rd_addr, VW'((t == L + 1) ? 0 : c + 1));
      chk("bias_iv", sa_bias_iv, VW'(in_bias));
      chk("bias_col", bias_col_o, in_bias ? mem_b[c] : 64'd0);
      chk("row_A", row_A_o, er);              chk("col_W", col_W_o, ew);
      chk("out_wr_en", out_wr_en, VW'(e_wr));
      if (e_wr) begin
        chk("out_wr_addr", out_wr_addr, VW'(w - d)); chk("out_wr_data", out_wr_data, pcol[w-d]);
      end
      chk("err", err, VW'((t >= tdone) ? e_err : 0));
      if (out_wr_en) nwr++;
      if (done) ndone++;
      sample_reqs();
      if (t == abort_t) begin
        #2 nrst = 1'b0;
        #1;
        chk("rst_busy", busy, 64'd0);   chk("rst_sa_iv", sa_iv, 64'd0);
        chk("rst_mac_iv", sa_mac_iv, 64'd0); chk("rst_a_rd", a_rd_en, 64'd0);
        chk("rst_w_rd", w_rd_en, 64'd0); chk("rst_row", row_A_o, 64'd0);
        chk("rst_col", col_W_o, 64'd0); chk("rst_wr", out_wr_en, 64'd0);
        chk("rst_done", done, 64'd0);
        p_a = 1'b0; p_w = 1'b0; p_b = 1'b0;
        respond();
        nrst = 1'b1; start = 1'b0; sa_ov = 1'b0; last_err = 0;
        return;
      end
      respond();
    end
    start = 1'b0; sa_ov = 1'b0;
    cur_t = tdone + 1;
    chk("n_writes", VW'(nwr), VW'(e_nwr));
    chk("n_done", VW'(ndone), 64'd1);
    if (tab_nwr >= 0) chk("tab_writes", VW'(nwr), VW'(tab_nwr));
    if (tab_err >= 0) chk("tab_err", err, VW'(tab_err));
    last_err = e_err;
  endtask

  initial begin
    tab[0] = '{8,   3,  8,  1'b0, 0, 8};
    tab[1] = '{1,   0,  8,  1'b0, 0, 8};
    tab[2] = '{5,   0,  -1, 1'b0, 1, 0};
    tab[3] = '{3,   2,  5,  1'b0, 1, 5};
    tab[4] = '{12,  1,  8,  1'b1, 0, 8};
    tab[5] = '{256, 4,  8,  1'b0, 0, 8};
    tab[6] = '{2,   63, 8,  1'b0, 0, 8};
    tab[7] = '{10,  0,  1,  1'b1, 1, 1};

    nrst = 1'b0; start = 1'b0; k_len = '0; sa_ov = 1'b0;
    a_rd_data = junk(); w_rd_data = junk(); b_rd_data = junk(); psum_i = junk();
    p_a = 1'b0; p_w = 1'b0; p_b = 1'b0; p_aa = '0; p_wa = '0; p_ba = '0;
    #1;
    idle_cycles(2, 0);
    #2 nrst = 1'b1;
    idle_cycles(20, 0);

    foreach (tab[i]) begin
      run_tile(tab[i].k, tab[i].d, tab[i].cols, tab[i].mid, -1, tab[i].e_err, tab[i].e_nwr);
      idle_cycles(2, last_err);
    end

    // Timeout leaves err set; a K=0 start clears it and finishes on the very next cycle.
    run_tile(4, 0, -1, 1'b0, -1, 1, 0);
    idle_cycles(2, 1);
    start = 1'b1; k_len = '0;
    @(negedge clk); sample_reqs(); respond();
    start = 1'b0;
    @(negedge clk); cur_t = 0;
    chk("k0_done", done, 64'd1);     chk("k0_busy", busy, 64'd0);
    chk("k0_sa_iv", sa_iv, 64'd0);   chk("k0_a_rd", a_rd_en, 64'd0);
    chk("k0_w_rd", w_rd_en, 64'd0);  chk("k0_b_rd", b_rd_en, 64'd0);
    chk("k0_err", err, 64'd0);
    sample_reqs(); respond();
    idle_cycles(3, 0);

    // Reset mid-MAC, then a clean tile.
    run_tile(10, 3, 8, 1'b0, 6, -1, -1);
    idle_cycles(3, 0);
    run_tile(10, 3, 8, 1'b0, -1, 0, 8);
    idle_cycles(2, last_err);

    for (int r = 0; r < 12; r++) begin
      int k, d, cols, sel;
      k = $urandom_range(1, 20);
      sel = $urandom_range(0, 3);
      cols = (sel == 0) ? -1 : (sel == 1) ? $urandom_range(1, N-1) : N;
      d = ($urandom_range(0, 4) == 0) ? OVT - 1 : $urandom_range(0, 10);
      run_tile(k, d, cols, 1'($urandom), -1, -1, -1);
      idle_cycles(2, last_err);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
